// File: rtl/pic_inta_sequencer.sv
// 8086-mode interrupt acknowledge sequencer for the 8259: raises INT, tracks both
// INTA pulses, and drives the IRR/ISR controls, vector byte and cascade ID.
module pic_inta_sequencer #(
  parameter int INT_HOLDOFF    = 0,
  parameter int SPURIOUS_LEVEL = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       write_initial_command_word_1,
  input  logic [7:0] interrupt,
  input  logic       inta_n,
  input  logic [4:0] icw2_vector,
  input  logic       auto_eoi,
  input  logic       sngl,
  input  logic       sp_en,
  input  logic [7:0] icw3,
  input  logic [2:0] cascade_in,
  output logic       int_out,
  output logic       freeze,
  output logic       latch_in_service,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] acknowledge_interrupt,
  output logic       end_of_acknowledge_sequence,
  output logic [7:0] aeoi_clear,
  output logic [7:0] data_out,
  output logic       data_out_en,
  output logic [2:0] cascade_out,
  output logic       cascade_drive_en
);

  typedef enum logic [2:0] {IDLE, REQ, ACK1, WAIT2, ACK2} state_t;

  localparam logic [2:0] SPUR_LEVEL = SPURIOUS_LEVEL[2:0];
  localparam logic [3:0] HOLDOFF_LOAD = INT_HOLDOFF[3:0];

  state_t     state;
  logic       inta_prev;
  logic       spurious;
  logic [3:0] holdoff;
  logic       fall;
  logic       rise;
  logic [2:0] req_level;
  logic [2:0] ack_level;
  logic [2:0] first_level;
  logic       is_master;
  logic       is_slave;

  function automatic logic [2:0] level_of(input logic [7:0] onehot);
    logic [2:0] lvl;
    lvl = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) lvl = i[2:0];
    end
    return lvl;
  endfunction

  assign fall        = inta_prev & ~inta_n;
  assign rise        = ~inta_prev & inta_n;
  assign req_level   = level_of(interrupt);
  assign ack_level   = level_of(acknowledge_interrupt);
  assign first_level = (interrupt != 8'd0) ? req_level : SPUR_LEVEL;
  assign is_master   = ~sngl & sp_en;
  assign is_slave    = ~sngl & ~sp_en;

  // Reset clears the history so a low inta_n out of reset is not seen as a fall.
  always_ff @(posedge clk) begin
    if (reset) inta_prev <= 1'b0;
    else       inta_prev <= inta_n;
  end

  always_ff @(posedge clk) begin
    if (reset || write_initial_command_word_1) begin
      state                       <= IDLE;
      spurious                    <= 1'b0;
      holdoff                     <= 4'd0;
      int_out                     <= 1'b0;
      freeze                      <= 1'b0;
      latch_in_service            <= 1'b0;
      clear_interrupt_request     <= 8'd0;
      acknowledge_interrupt       <= 8'd0;
      end_of_acknowledge_sequence <= 1'b0;
      aeoi_clear                  <= 8'd0;
      data_out                    <= 8'd0;
      data_out_en                 <= 1'b0;
      cascade_out                 <= 3'd0;
      cascade_drive_en            <= 1'b0;
    end else begin
      latch_in_service            <= 1'b0;
      clear_interrupt_request     <= 8'd0;
      end_of_acknowledge_sequence <= 1'b0;
      aeoi_clear                  <= 8'd0;
      if (holdoff != 4'd0) holdoff <= holdoff - 4'd1;

      case (state)
        IDLE: begin
          if (interrupt != 8'd0 && holdoff == 4'd0) begin
            state   <= REQ;
            int_out <= 1'b1;
          end
        end
        REQ: begin
          if (fall) begin
            state   <= ACK1;
            int_out <= 1'b0;
            freeze  <= 1'b1;
            if (interrupt != 8'd0) begin
              acknowledge_interrupt   <= interrupt;
              latch_in_service        <= 1'b1;
              clear_interrupt_request <= interrupt;
              spurious                <= 1'b0;
            end else begin
              acknowledge_interrupt   <= 8'd1 << SPUR_LEVEL;
              spurious                <= 1'b1;
            end
            // A slave on this level supplies the vector; the master only names it on CAS.
            if (is_master && icw3[first_level] && interrupt != 8'd0) begin
              cascade_out      <= first_level;
              cascade_drive_en <= 1'b1;
            end
          end
        end
        ACK1: begin
          if (rise) state <= WAIT2;
        end
        WAIT2: begin
          if (fall) begin
            state <= ACK2;
            if (cascade_drive_en) begin
              data_out    <= 8'd0;
              data_out_en <= 1'b0;
            end else begin
              data_out    <= {icw2_vector, ack_level};
              data_out_en <= is_slave ? (cascade_in == icw3[2:0]) : 1'b1;
            end
          end
        end
        ACK2: begin
          if (rise) begin
            state                       <= IDLE;
            end_of_acknowledge_sequence <= 1'b1;
            if (auto_eoi && !spurious) aeoi_clear <= acknowledge_interrupt;
            spurious              <= 1'b0;
            freeze                <= 1'b0;
            acknowledge_interrupt <= 8'd0;
            data_out              <= 8'd0;
            data_out_en           <= 1'b0;
            cascade_out           <= 3'd0;
            cascade_drive_en      <= 1'b0;
            holdoff               <= HOLDOFF_LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pic_inta_sequencer.md
Name: pic_inta_sequencer

Overview:
- Sequences the 8086-mode interrupt acknowledge cycle of the 8259 block.
- Raises INT toward the CPU when the priority resolver presents a winning request, and tracks the two INTA pulses.
- Generates the freeze, latch_in_service and clear_interrupt_request controls consumed by the IRR/ISR.
- Drives the vector byte and cascade ID, and issues end-of-acknowledge and auto-EOI clears.

Parameters:
INT_HOLDOFF, 0, cycles (0..15) after end of acknowledge before int_out may reassert
SPURIOUS_LEVEL, 7, level reported when the request vanishes before the first INTA

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
write_initial_command_word_1  input  1  ICW1 write strobe; aborts any sequence
interrupt  input  8  one-hot winning request from priority resolver, 0 = none
inta_n  input  1  CPU INTA, active low, already synchronous to clk
icw2_vector  input  5  ICW2[7:3], vector T7..T3
auto_eoi  input  1  ICW4 AEOI
sngl  input  1  single mode (no cascade)
sp_en  input  1  1 = master, 0 = slave (ignored when sngl=1)
icw3  input  8  master: slave-present mask; slave: ID in [2:0]
cascade_in  input  3  CAS lines as seen by a slave
int_out  output  1  INT to CPU
freeze  output  1  holds IRR/priority stable during acknowledge
latch_in_service  output  1  1-cycle pulse: set ISR bit of acknowledge_interrupt
clear_interrupt_request  output  8  1-cycle pulse: clear IRR bit
acknowledge_interrupt  output  8  one-hot level under acknowledge
end_of_acknowledge_sequence  output  1  1-cycle pulse at end of second INTA
aeoi_clear  output  8  1-cycle ISR clear when auto_eoi=1
data_out  output  8  vector byte
data_out_en  output  1  data buffer drive enable
cascade_out  output  3  CAS ID driven by master
cascade_drive_en  output  1  master CAS drive enable

Behaviour:
- Edge detect:
  - inta_prev register, reset to 0.
  - fall = inta_prev & ~inta_n; rise = ~inta_prev & inta_n.
  - No false fall after reset even if inta_n is low.
- Timing: all outputs are registered. An event detected in cycle N is visible in cycle N+1.
- Reset values: every output 0, state IDLE, holdoff counter 0.
- Priority within a cycle: reset > write_initial_command_word_1 > FSM.
  - ICW1 forces IDLE and clears all outputs and the counter, exactly as reset does.
- States:
  - IDLE: when interrupt!=0 and holdoff==0 -> REQ, int_out=1. A fall is ignored.
  - REQ: int_out stays 1 even if interrupt drops. On fall -> ACK1:
    - int_out=0, freeze=1.
    - If interrupt!=0: acknowledge_interrupt=interrupt; latch_in_service and clear_interrupt_request=interrupt are pulsed one cycle.
    - If interrupt==0 (spurious): acknowledge_interrupt=1<<SPURIOUS_LEVEL; no latch_in_service or clear pulse; a spurious flag is set.
  - ACK1: on rise -> WAIT2.
  - WAIT2: on fall -> ACK2; drive decision below.
  - ACK2: on rise -> IDLE with:
    - end_of_acknowledge_sequence pulse.
    - aeoi_clear=acknowledge_interrupt pulse if auto_eoi=1 and not spurious.
    - data_out_en=0, data_out=0, cascade_drive_en=0, cascade_out=0, freeze=0, acknowledge_interrupt=0.
    - Holdoff counter loads INT_HOLDOFF.
- Level L = binary index of acknowledge_interrupt (3 bits).
- Cascade master (sngl=0, sp_en=1, icw3[L]=1, not spurious):
  - From ACK1 entry: cascade_out=L, cascade_drive_en=1, held until end.
  - data_out_en stays 0 in ACK2.
- Cascade slave (sngl=0, sp_en=0):
  - At the second fall, data_out_en=1 only if cascade_in==icw3[2:0]; otherwise 0.
  - The sequence still completes either way.
- Otherwise (single, or master with non-slave level):
  - At the second fall, data_out={icw2_vector,L}, data_out_en=1.
- Holdoff counter: 4-bit, decrements to 0 in every state; IDLE cannot raise int_out while it is nonzero.
- Falls in ACK1/ACK2 and rises in REQ/WAIT2 are ignored; no lock-up.

Test Plan:
- Single mode, icw2_vector=5'b01000, interrupt=8'h08, two INTA pulses:
  - int_out rises in cycle after request.
  - First fall: latch_in_service and clear_interrupt_request=8'h08 for one cycle, freeze=1.
  - Second fall: data_out=8'h43, data_out_en=1.
  - Second rise: end pulse, freeze=0.
- Same as above with auto_eoi=1 -> aeoi_clear=8'h08 in the same cycle as end_of_acknowledge_sequence.
- Spurious: interrupt drops to 0 before first fall:
  - No latch_in_service pulse.
  - data_out={icw2_vector,3'd7}.
  - No aeoi_clear even with auto_eoi=1.
- Master, icw3=8'h04, interrupt=8'h04:
  - cascade_out=3'd2 and cascade_drive_en=1 from ACK1 through end.
  - data_out_en stays 0.
- Slave, icw3[2:0]=3'd3:
  - cascade_in=3 at second fall -> data_out_en=1.
  - Repeat with cascade_in=1 -> data_out_en=0, end pulse still issued.
- Abort and holdoff:
  - ICW1 strobe in WAIT2 -> all outputs 0, IDLE next cycle.
  - Reset with inta_n held low -> no fall detected.
  - INT_HOLDOFF=3 -> int_out reasserts no earlier than 3 cycles after end pulse.
